// File: rtl/pipe_mux_tree_if.sv
// rtl/pipe_mux_tree_if.sv - request/result handshake bundle for pipe_mux_tree
interface pipe_mux_tree_if #(
  parameter int WIDTH    = 64,
  parameter int SEL_BITS = 3
);
  localparam int N = 1 << SEL_BITS;

  logic                  in_valid;
  logic                  in_ready;
  logic [N*WIDTH-1:0]    data_in;
  logic [SEL_BITS-1:0]   select;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_BITS-1:0]   out_sel;

  modport slave (
    input  in_valid, data_in, select, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, data_in, select, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/pipe_mux_tree.sv
// rtl/pipe_mux_tree.sv - pipelined N:1 word mux, one register stage per tree level
// Level k halves the word set using select bit k; ready ripples back so bubbles collapse.
module pipe_mux_tree #(
  parameter int WIDTH    = 64,
  parameter int SEL_BITS = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  pipe_mux_tree_if.slave bus
);
  logic [SEL_BITS-1:0] valid_vec;
  logic [SEL_BITS:0]   ready;
  logic                in_ready_int;

  always_comb begin
    ready           = '0;
    ready[SEL_BITS] = bus.out_ready;
    for (int k = SEL_BITS - 1; k >= 0; k--) begin
      ready[k] = !valid_vec[k] | ready[k+1];
    end
  end

  assign in_ready_int = ready[0] & !flush;
  assign bus.in_ready = in_ready_int;

  for (genvar k = 0; k < SEL_BITS; k++) begin : lvl
    localparam int M = 1 << (SEL_BITS - k - 1);

    logic                valid_q;
    logic [SEL_BITS-1:0] sel_q;
    logic [WIDTH-1:0]    word_q [M];

    logic                src_valid;
    logic [SEL_BITS-1:0] src_sel;
    logic [WIDTH-1:0]    src_word [2*M];

    if (k == 0) begin : g_src
      assign src_valid = bus.in_valid & in_ready_int;
      assign src_sel   = bus.select;
      for (genvar j = 0; j < 2*M; j++) begin : g_w
        assign src_word[j] = bus.data_in[j*WIDTH +: WIDTH];
      end
    end else begin : g_src
      assign src_valid = lvl[k-1].valid_q;
      assign src_sel   = lvl[k-1].sel_q;
      for (genvar j = 0; j < 2*M; j++) begin : g_w
        assign src_word[j] = lvl[k-1].word_q[j];
      end
    end

    assign valid_vec[k] = valid_q;

    // Payload only loads with a real word so an idle output keeps its last value.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        valid_q <= 1'b0;
        sel_q   <= '0;
        for (int j = 0; j < M; j++) begin
          word_q[j] <= '0;
        end
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (ready[k]) begin
        valid_q <= src_valid;
        if (src_valid) begin
          sel_q <= src_sel;
          for (int j = 0; j < M; j++) begin
            word_q[j] <= src_sel[k] ? src_word[2*j+1] : src_word[2*j];
          end
        end
      end
    end
  end

  assign bus.out_valid = lvl[SEL_BITS-1].valid_q;
  assign bus.out_data  = lvl[SEL_BITS-1].word_q[0];
  assign bus.out_sel   = lvl[SEL_BITS-1].sel_q;
endmodule

// File: tb/tb_pipe_mux_tree.sv
// tb/tb_pipe_mux_tree.sv - directed self-checking bench for pipe_mux_tree
module tb_pipe_mux_tree;
  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic flush_a = 1'b0;
  logic flush_b = 1'b0;

  always #5 clk = ~clk;

  pipe_mux_tree_if #(.WIDTH(8),  .SEL_BITS(3)) a_if ();
  pipe_mux_tree_if #(.WIDTH(64), .SEL_BITS(1)) b_if ();

  pipe_mux_tree #(.WIDTH(8), .SEL_BITS(3)) u_a (
    .clk   (clk),
    .reset (reset),
    .flush (flush_a),
    .bus   (a_if)
  );

  pipe_mux_tree #(.WIDTH(64), .SEL_BITS(1)) u_b (
    .clk   (clk),
    .reset (reset),
    .flush (flush_b),
    .bus   (b_if)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  localparam logic [63:0] B_W0 = 64'h0123456789abcdef;
  localparam logic [63:0] B_W1 = 64'hfedcba9876543210;

  int tx;
  int rx;

  initial begin
    a_if.in_valid  = 1'b0;
    a_if.select    = '0;
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) a_if.data_in[i*8 +: 8] = 8'(8'h10 + i);
    b_if.in_valid  = 1'b0;
    b_if.select    = '0;
    b_if.out_ready = 1'b1;
    b_if.data_in   = {B_W1, B_W0};

    // reset state
    #1;
    check("rst_out_valid", 64'(a_if.out_valid), 64'd0);
    check("rst_out_data",  64'(a_if.out_data),  64'd0);
    check("rst_out_sel",   64'(a_if.out_sel),   64'd0);
    #12 reset = 1'b1;
    tick();
    check("rst_in_ready", 64'(a_if.in_ready), 64'd1);

    // 1: latency
    a_if.select = 3'd5; a_if.in_valid = 1'b1;
    #1 check("s1_in_ready", 64'(a_if.in_ready), 64'd1);
    tick();
    a_if.in_valid = 1'b0;
    check("s1_c1_valid", 64'(a_if.out_valid), 64'd0);
    tick();
    check("s1_c2_valid", 64'(a_if.out_valid), 64'd0);
    tick();
    check("s1_c3_valid", 64'(a_if.out_valid), 64'd1);
    check("s1_c3_data",  64'(a_if.out_data),  64'h15);
    check("s1_c3_sel",   64'(a_if.out_sel),   64'd5);
    tick();
    check("s1_c4_valid", 64'(a_if.out_valid), 64'd0);
    check("s1_hold_data", 64'(a_if.out_data), 64'h15);

    // 2: streaming
    for (int c = 0; c < 11; c++) begin
      a_if.in_valid = (c < 8);
      a_if.select   = 3'(c);
      #1;
      if (c < 8) check("s2_in_ready", 64'(a_if.in_ready), 64'd1);
      tick();
      check("s2_out_valid", 64'(a_if.out_valid), 64'((c >= 2) && (c <= 9)));
      if (c >= 2 && c <= 9) check("s2_out_data", 64'(a_if.out_data), 64'(8'h10 + (c - 2)));
    end

    // 3: backpressure
    tx = 0; rx = 0;
    for (int c = 0; c < 18; c++) begin
      a_if.out_ready = !(c >= 3 && c <= 7);
      a_if.in_valid  = (tx < 8);
      a_if.select    = 3'(7 - tx);
      #1;
      if (c >= 3 && c <= 7) begin
        check("s3_stall_in_ready", 64'(a_if.in_ready), 64'd0);
        check("s3_stall_data",     64'(a_if.out_data), 64'h17);
      end
      if (c >= 8 && c <= 15) check("s3_flow_valid", 64'(a_if.out_valid), 64'd1);
      if (a_if.out_valid && a_if.out_ready) begin
        check("s3_order", 64'(a_if.out_data), 64'(8'(8'h17 - rx)));
        rx++;
      end
      if (a_if.in_valid && a_if.in_ready) tx++;
      tick();
    end
    a_if.in_valid = 1'b0;
    check("s3_count", 64'(rx), 64'd8);

    // 4: bubble collapse under output stall
    a_if.out_ready = 1'b0;
    a_if.select = 3'd1; a_if.in_valid = 1'b1;
    #1 check("s4_a_ready", 64'(a_if.in_ready), 64'd1);
    tick();
    a_if.in_valid = 1'b0;
    tick();
    tick();
    check("s4_a_out", 64'(a_if.out_data), 64'h11);
    a_if.select = 3'd2; a_if.in_valid = 1'b1;
    #1 check("s4_b_ready", 64'(a_if.in_ready), 64'd1);
    tick();
    a_if.in_valid = 1'b0;
    tick();
    a_if.select = 3'd3; a_if.in_valid = 1'b1;
    #1 check("s4_c_ready", 64'(a_if.in_ready), 64'd1);
    tick();
    a_if.select = 3'd4;
    #1 check("s4_full_ready", 64'(a_if.in_ready), 64'd0);
    check("s4_stall_data", 64'(a_if.out_data), 64'h11);
    a_if.in_valid = 1'b0; a_if.out_ready = 1'b1;
    tick();
    check("s4_b_out", 64'(a_if.out_data), 64'h12);
    tick();
    check("s4_c_out", 64'(a_if.out_data), 64'h13);
    tick();
    check("s4_drained", 64'(a_if.out_valid), 64'd0);

    // 5: flush
    for (int c = 0; c < 3; c++) begin
      a_if.select = 3'(c); a_if.in_valid = 1'b1;
      tick();
    end
    check("s5_pre_data", 64'(a_if.out_data), 64'h10);
    flush_a = 1'b1; a_if.select = 3'd6;
    #1 check("s5_flush_ready", 64'(a_if.in_ready), 64'd0);
    tick();
    flush_a = 1'b0;
    check("s5_post_valid", 64'(a_if.out_valid), 64'd0);
    #1 check("s5_resume_ready", 64'(a_if.in_ready), 64'd1);
    tick();
    a_if.in_valid = 1'b0;
    check("s5_e1_valid", 64'(a_if.out_valid), 64'd0);
    tick();
    check("s5_e2_valid", 64'(a_if.out_valid), 64'd0);
    tick();
    check("s5_e3_valid", 64'(a_if.out_valid), 64'd1);
    check("s5_e3_data",  64'(a_if.out_data),  64'h16);
    tick();
    check("s5_e4_valid", 64'(a_if.out_valid), 64'd0);

    // 6: asynchronous reset while full
    a_if.out_ready = 1'b0;
    for (int c = 3; c < 6; c++) begin
      a_if.select = 3'(c); a_if.in_valid = 1'b1;
      tick();
    end
    a_if.in_valid = 1'b0;
    check("s6_full_data", 64'(a_if.out_data), 64'h13);
    reset = 1'b0;
    #1;
    check("s6_rst_valid", 64'(a_if.out_valid), 64'd0);
    check("s6_rst_data",  64'(a_if.out_data),  64'd0);
    check("s6_rst_sel",   64'(a_if.out_sel),   64'd0);
    reset = 1'b1;
    a_if.select = 3'd2; a_if.in_valid = 1'b1; a_if.out_ready = 1'b1;
    #1 check("s6_rel_ready", 64'(a_if.in_ready), 64'd1);
    tick();
    a_if.in_valid = 1'b0;
    tick();
    tick();
    check("s6_resume_valid", 64'(a_if.out_valid), 64'd1);
    check("s6_resume_data",  64'(a_if.out_data),  64'h12);

    // SEL_BITS=1, WIDTH=64: latency 1, back-to-back
    b_if.select = 1'b1; b_if.in_valid = 1'b1;
    #1 check("b_in_ready", 64'(b_if.in_ready), 64'd1);
    tick();
    check("b_w1_valid", 64'(b_if.out_valid), 64'd1);
    check("b_w1_data",  b_if.out_data, B_W1);
    check("b_w1_sel",   64'(b_if.out_sel), 64'd1);
    b_if.select = 1'b0;
    tick();
    b_if.in_valid = 1'b0;
    check("b_w0_data", b_if.out_data, B_W0);
    check("b_w0_sel",  64'(b_if.out_sel), 64'd0);
    tick();
    check("b_idle_valid", 64'(b_if.out_valid), 64'd0);
    check("b_hold_data",  b_if.out_data, B_W0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
